morse_playback_scheduler: RTL and testbench
===========================================

// Module: morse_playback_scheduler
// PURPOSE
//  Sequences playback of the encoder's character buffer onto the buzzer. Walks char 0..N-1,
//  fetches each char's morse pattern via a char_idx lookup, then times tone / element-gap /
//  char-gap / word-gap intervals in dot units and drives tone_en to the buzzer.
//  Sits between the character register/encoder lookup and the buzzer.
// PARAMETERS
//  UNIT_CYCLES  25_000_000  clk cycles per dot unit at normal speed (>=2)
//  CNT_W        25          width of unit cycle counter; must hold UNIT_CYCLES-1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  start      in   1  begin playback (level sampled in IDLE only)
//  abort      in   1  stop playback immediately; priority over start
//  char_count in   4  valid chars in buffer, 0..8; >8 clamped to 8; latched on start
//  sw_lc      in   2  dash length = sw_lc+2 units (2..5); latched on start
//  sw_sc      in   2  dot length = sw_sc+1 units (1..4); latched on start
//  sw_ss      in   1  speed: 0 unit=UNIT_CYCLES, 1 unit=UNIT_CYCLES>>1; latched on start
//  code_bits  in   5  pattern of char at char_idx; bit i = element i (1 dash, 0 dot), bit0 first
//  code_len   in   3  element count 1..5 (>5 treated as 5); 0 = space (word gap)
//  char_idx   out  3  buffer index being played
//  tone_en    out  1  buzzer enable, high during tone intervals only
//  busy       out  1  high whenever state != IDLE
//  done       out  1  one-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state IDLE; char_idx=0, tone_en=0, busy=0, done=0; all counters and latches 0.
//  All outputs registered. Unit timer: cycle counter clears on every state entry; a unit tick
//   fires when it reaches unit_len-1; unit counter counts ticks to the interval length.
//  States / transitions:
//   IDLE : start & !abort -> LOAD (char_idx=0, latch count/switches); if clamped count==0 -> DONE.
//          start while not IDLE is ignored.
//   LOAD : 1 cycle; samples code_bits/code_len (lookup is combinational on char_idx, stable here).
//          len==0 -> WGAP; else elem=0 -> TONE.
//   TONE : tone_en=1 for dot/dash units per code_bits[elem]. End: elem==len-1 ->
//          (last char ? DONE : CGAP); else EGAP.
//   EGAP : 1 unit silent -> TONE with elem+1 (no reload).
//   CGAP : 3 units silent -> char_idx+1, LOAD.
//   WGAP : 4 units silent (adds to preceding CGAP for 7-unit word gap) ->
//          last char ? DONE : char_idx+1, LOAD.
//   DONE : done=1 for this cycle, busy=1 -> IDLE.
//  Latency: start sampled at cycle 0 -> LOAD in cycle 1 -> tone_en high from cycle 2.
//  abort in any non-IDLE state: next cycle IDLE, tone_en=0, busy=0, no done pulse; char_idx->0.
//  abort and interval end in the same cycle: abort wins.
//  Switch/char_count changes during playback have no effect until next start.
//  char_idx never wraps: last char = latched count-1; playback never exceeds index 7.
// TESTING (UNIT_CYCLES=4, sw_ss=0, sw_sc=0, sw_lc=1 unless stated)
//  1 count=1 'E'(len1,bits0), start@0 -> tone_en high cycles 2..5; done=1 cycle 6; busy=0 cycle 7.
//  2 count=1 'A'(len2,bits 2'b10) -> tone 4 cycles, low 4 (EGAP), high 12 (dash=3u), then done.
//  3 count=2 'E','E' -> tones of 4 separated by exactly 13 low cycles (CGAP 12 + LOAD 1).
//  4 count=3 'E',space,'E' -> low gap 30 cycles (CGAP12+LOAD1+WGAP16+LOAD1); sw_ss=1 halves unit.
//  5 abort mid-TONE of char 1 -> tone_en=0, busy=0 next cycle, no done; restart plays from idx 0.
//  6 count=0 start -> done pulse cycle 1, tone_en never high; count=12 -> 8 chars played, idx max 7.

Source files
------------

// File: rtl/morse_playback_scheduler.sv
// rtl/morse_playback_scheduler.sv - walks the character buffer and times morse tone/gap intervals onto the buzzer
module morse_playback_scheduler #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] char_count,
  input  logic [1:0] sw_lc,
  input  logic [1:0] sw_sc,
  input  logic       sw_ss,
  input  logic [4:0] code_bits,
  input  logic [2:0] code_len,
  output logic [2:0] char_idx,
  output logic       tone_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TONE,
    S_EGAP,
    S_CGAP,
    S_WGAP,
    S_DONE
  } state_t;

  // Terminal values of the cycle counter for normal and double speed.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((UNIT_CYCLES >> 1) - 1);

  state_t           state_q;
  state_t           next_state;
  logic [3:0]       count_q;
  logic [1:0]       lc_q;
  logic [1:0]       sc_q;
  logic             ss_q;
  logic [4:0]       bits_q;
  logic [2:0]       len_q;
  logic [2:0]       elem_q;
  logic [CNT_W-1:0] cyc_q;
  logic [2:0]       units_q;

  logic             unit_tick;
  logic [2:0]       interval_units;
  logic             interval_end;
  logic             last_char;
  logic [3:0]       count_clamped;
  logic [2:0]       len_clamped;

  // Interval timing, char position and input clamping.
  always_comb begin
    unit_tick      = (cyc_q == (ss_q ? HALF_LAST : FULL_LAST));
    interval_units = 3'd1;
    case (state_q)
      S_TONE:  interval_units = bits_q[elem_q] ? ({1'b0, lc_q} + 3'd2) : ({1'b0, sc_q} + 3'd1);
      S_EGAP:  interval_units = 3'd1;
      S_CGAP:  interval_units = 3'd3;
      S_WGAP:  interval_units = 3'd4;
      default: interval_units = 3'd1;
    endcase
    interval_end  = unit_tick && (units_q == interval_units - 3'd1);
    last_char     = ({1'b0, char_idx} == count_q - 4'd1);
    count_clamped = (char_count > 4'd8) ? 4'd8 : char_count;
    len_clamped   = (code_len > 3'd5) ? 3'd5 : code_len;
  end

  // Next-state selection; abort from any active state wins over everything.
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = (count_clamped == 4'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        next_state = (len_clamped == 3'd0) ? S_WGAP : S_TONE;
      end
      S_TONE: begin
        if (interval_end) begin
          if (elem_q == len_q - 3'd1) begin
            next_state = last_char ? S_DONE : S_CGAP;
          end else begin
            next_state = S_EGAP;
          end
        end
      end
      S_EGAP: begin
        if (interval_end) next_state = S_TONE;
      end
      S_CGAP: begin
        if (interval_end) next_state = S_LOAD;
      end
      S_WGAP: begin
        if (interval_end) next_state = last_char ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) next_state = S_IDLE;
  end

  // State register, registered outputs, timers and playback latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      lc_q     <= '0;
      sc_q     <= '0;
      ss_q     <= 1'b0;
      bits_q   <= '0;
      len_q    <= '0;
      elem_q   <= '0;
      cyc_q    <= '0;
      units_q  <= '0;
      char_idx <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= next_state;
      tone_en <= (next_state == S_TONE);
      busy    <= (next_state != S_IDLE);
      done    <= (next_state == S_DONE);

      if (next_state != state_q || state_q == S_IDLE) begin
        cyc_q   <= '0;
        units_q <= '0;
      end else if (unit_tick) begin
        cyc_q   <= '0;
        units_q <= units_q + 3'd1;
      end else begin
        cyc_q   <= cyc_q + 1'b1;
      end

      if (state_q == S_IDLE && start && !abort) begin
        count_q  <= count_clamped;
        lc_q     <= sw_lc;
        sc_q     <= sw_sc;
        ss_q     <= sw_ss;
        char_idx <= '0;
      end

      if (state_q == S_LOAD) begin
        bits_q <= code_bits;
        len_q  <= len_clamped;
        elem_q <= '0;
      end

      if (state_q == S_EGAP && next_state == S_TONE) begin
        elem_q <= elem_q + 3'd1;
      end

      if ((state_q == S_CGAP || state_q == S_WGAP) && next_state == S_LOAD) begin
        char_idx <= char_idx + 3'd1;
      end

      if (abort && state_q != S_IDLE) begin
        char_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_morse_playback_scheduler.sv
// tb/tb_morse_playback_scheduler.sv - scoreboard bench for morse_playback_scheduler
module tb_morse_playback_scheduler;

  localparam int UC = 4;
  localparam int K_GAP = 0, K_TONE = 1, K_END = 2, K_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] char_count = '0;
  logic [1:0] sw_lc = 2'd1;
  logic [1:0] sw_sc = 2'd0;
  logic       sw_ss = 1'b0;
  logic [4:0] code_bits;
  logic [2:0] code_len;
  logic [2:0] char_idx;
  logic       tone_en;
  logic       busy;
  logic       done;

  logic [4:0] buf_bits [8];
  logic [2:0] buf_len  [8];

  typedef struct {
    int kind;
    int val;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  morse_playback_scheduler #(.UNIT_CYCLES(UC), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .char_count (char_count),
    .sw_lc      (sw_lc),
    .sw_sc      (sw_sc),
    .sw_ss      (sw_ss),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .char_idx   (char_idx),
    .tone_en    (tone_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Combinational encoder lookup on the playback index.
  assign code_bits = buf_bits[char_idx];
  assign code_len  = buf_len[char_idx];

  task automatic check_ev(input int kind, input int val, input int idx);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d idx=%0d, expected none", kind, val, idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.idx != idx) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%0d idx=%0d, expected kind=%0d val=%0d idx=%0d",
                 kind, val, idx, e.kind, e.val, e.idx);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: turns the DUT's tone/busy/done waveform into run-length events.
  int   mon_low = 0;
  int   mon_hi = 0;
  logic mon_pt = 1'b0;
  logic mon_pb = 1'b0;
  bit   mon_saw_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_low = 0;
      mon_hi = 0;
      mon_pt = 1'b0;
      mon_pb = 1'b0;
      mon_saw_done = 1'b0;
    end else begin
      if (tone_en && !mon_pt) begin
        check_ev(K_GAP, mon_low, 0);
        mon_low = 0;
      end
      if (!tone_en && mon_pt) begin
        check_ev(K_TONE, mon_hi, 0);
        mon_hi = 0;
      end
      if (tone_en) mon_hi++;
      else if (busy) mon_low++;
      if (done) begin
        check_ev(K_END, mon_low, int'(char_idx));
        mon_low = 0;
        mon_saw_done = 1'b1;
      end
      if (!busy && mon_pb) begin
        if (!mon_saw_done) check_ev(K_ABORT, mon_low, 0);
        mon_low = 0;
        mon_hi = 0;
        mon_saw_done = 1'b0;
      end
      mon_pt = tone_en;
      mon_pb = busy;
    end
  end

  // Reference: per-cycle tone level from the cycle after start through the done cycle.
  task automatic build_trace(input int n, input int u, input int dot, input int dash, output bit tr[$]);
    int len;
    tr = {};
    for (int i = 0; i < n; i++) begin
      tr.push_back(1'b0);
      len = (buf_len[i] > 3'd5) ? 5 : int'(buf_len[i]);
      if (len == 0) begin
        repeat (4 * u) tr.push_back(1'b0);
      end else begin
        for (int e = 0; e < len; e++) begin
          if (e > 0) repeat (u) tr.push_back(1'b0);
          repeat ((buf_bits[i][e] ? dash : dot) * u) tr.push_back(1'b1);
        end
        if (i != n - 1) repeat (3 * u) tr.push_back(1'b0);
      end
    end
    tr.push_back(1'b0);
  endtask

  task automatic gen_events(input bit tr[$], input int used, input bit completed, input int end_idx);
    int low = 0;
    int hi = 0;
    bit p = 1'b0;
    for (int c = 0; c < used; c++) begin
      if (tr[c] && !p) begin
        exp_q.push_back('{K_GAP, low, 0});
        low = 0;
      end
      if (!tr[c] && p) begin
        exp_q.push_back('{K_TONE, hi, 0});
        hi = 0;
      end
      if (tr[c]) hi++;
      else low++;
      p = tr[c];
    end
    if (completed) begin
      exp_q.push_back('{K_END, low, end_idx});
    end else begin
      if (p) exp_q.push_back('{K_TONE, hi, 0});
      exp_q.push_back('{K_ABORT, low, 0});
    end
  endtask

  task automatic rand_buf();
    for (int i = 0; i < 8; i++) begin
      buf_bits[i] = 5'($urandom);
      buf_len[i]  = 3'($urandom_range(0, 7));
    end
  endtask

  // One playback using the current buffer, count and switch settings.
  task automatic play(input bit do_abort);
    int n, u, dot, dash, len_tr, k, to;
    bit tr[$];
    n    = (char_count > 4'd8) ? 8 : int'(char_count);
    u    = sw_ss ? (UC / 2) : UC;
    dot  = int'(sw_sc) + 1;
    dash = int'(sw_lc) + 2;
    build_trace(n, u, dot, dash, tr);
    len_tr = tr.size();
    k = 0;
    if (do_abort && len_tr >= 2) k = $urandom_range(1, len_tr - 1);
    if (k > 0) gen_events(tr, k, 1'b0, 0);
    else gen_events(tr, len_tr, 1'b1, (n > 0) ? n - 1 : 0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    char_count = 4'($urandom);
    sw_lc      = 2'($urandom);
    sw_sc      = 2'($urandom);
    sw_ss      = 1'($urandom);
    if (k > 0) begin
      repeat (k - 1) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    to = 0;
    while (busy && to < 4000) begin
      @(posedge clk);
      #1;
      to++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: busy still %0d after %0d cycles, expected 0", busy, to);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input int cnt, input int lc, input int sc, input int ss);
    char_count = 4'(cnt);
    sw_lc      = 2'(lc);
    sw_sc      = 2'(sc);
    sw_ss      = 1'(ss);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      buf_bits[i] = '0;
      buf_len[i]  = 3'd1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_tone_en", int'(tone_en), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_char_idx", int'(char_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // start together with abort in IDLE must not launch playback
    set_sw(3, 1, 0, 0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_idle_busy", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1;

    // 'E'
    buf_len[0] = 3'd1; buf_bits[0] = 5'b00000;
    set_sw(1, 1, 0, 0);
    play(1'b0);
    // 'A'
    buf_len[0] = 3'd2; buf_bits[0] = 5'b00010;
    set_sw(1, 1, 0, 0);
    play(1'b0);
    // 'E','E'
    buf_len[0] = 3'd1; buf_bits[0] = 5'b0;
    buf_len[1] = 3'd1; buf_bits[1] = 5'b0;
    set_sw(2, 1, 0, 0);
    play(1'b0);
    // 'E',space,'E' at both speeds
    buf_len[1] = 3'd0;
    buf_len[2] = 3'd1; buf_bits[2] = 5'b0;
    set_sw(3, 1, 0, 0);
    play(1'b0);
    set_sw(3, 1, 0, 1);
    play(1'b0);
    // empty buffer
    set_sw(0, 1, 0, 0);
    play(1'b0);
    // count above 8 clamps to 8 characters
    for (int i = 0; i < 8; i++) begin
      buf_len[i] = 3'($urandom_range(1, 7));
      buf_bits[i] = 5'($urandom);
    end
    set_sw(12, 0, 0, 1);
    play(1'b0);
    // abort, then a clean restart from index 0
    rand_buf();
    set_sw(4, 1, 0, 0);
    play(1'b1);
    set_sw(4, 1, 0, 0);
    play(1'b0);

    for (int r = 0; r < 40; r++) begin
      rand_buf();
      set_sw($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      play(r % 2 == 1);
    end

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
